// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Program-counter and fetch stage sitting directly in front of an
// asynchronous-read instruction memory. The PC register drives the memory
// address. The instruction that comes back is captured in the same cycle into
// a small FIFO, the fetch queue. The queue head is offered to decode over a
// valid/ready handshake. A taken branch or jump (redirect) flushes the queue
// and reloads the PC.
//
// Optional feature macro: IFETCH_BOUNDS_CHECK_EN
//   When it is defined, a fetch from a PC at or beyond IMEM_WORDS*4 is
//   refused. The unit parks in a FAULT state with fetch_fault raised until the
//   next redirect. When it is undefined there is no FAULT state, fetch_fault
//   is tied low, and out-of-range addresses are fetched as they are.
//
// Parameters
//   RESET_PC     PC loaded on reset
//   QUEUE_DEPTH  fetch-queue entries (power of two, 2..8)
//   IMEM_WORDS   instruction-memory size in 32-bit words (bounds check only)
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-low reset
//   imem_addr       byte address to instruction memory (the PC register)
//   imem_instr      instruction returned combinationally for imem_addr
//   redirect_valid  branch/jump taken this cycle
//   redirect_pc     redirect target; bits [1:0] are ignored
//   fe_valid        queue head is valid
//   fe_ready        decode accepts the head this cycle
//   fe_instr        instruction at the queue head
//   fe_pc           PC of fe_instr
//   fetch_fault     out-of-range fetch detected (bounds-check build only)
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned IMEM_WORDS  = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fe_valid,
  input  logic        fe_ready,
  output logic [31:0] fe_instr,
  output logic [31:0] fe_pc,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO_C = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1'b1);

  // Reject configurations that the pointer arithmetic cannot support.
  if ((QUEUE_DEPTH < 32'd2) || (QUEUE_DEPTH > 32'd8) ||
      ((QUEUE_DEPTH & (QUEUE_DEPTH - 32'd1)) != 32'd0) || (IMEM_WORDS == 32'd0)) begin : g_bad_params
    $error("instruction_fetch_unit: QUEUE_DEPTH must be a power of two in 2..8 and IMEM_WORDS non-zero");
  end

`ifdef IFETCH_BOUNDS_CHECK_EN
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [32:0] IMEM_BYTES_C = 33'(IMEM_WORDS) << 2;
`else
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1
  } state_e;
`endif

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [31:0]        q_pc_q    [QUEUE_DEPTH];
  logic [31:0]        q_instr_q [QUEUE_DEPTH];
`ifdef IFETCH_BOUNDS_CHECK_EN
  logic               fault_q, fault_d;
  logic               oob_s;
`endif

  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               redirect_act_s;
  logic [31:0]        target_s;

  // The head entry is valid whenever the queue holds anything. Data comes
  // straight from queue registers, so nothing from imem_instr reaches decode
  // combinationally.
  assign fe_valid  = (count_q != CNT_ZERO_C);
  assign fe_pc     = q_pc_q[head_q];
  assign fe_instr  = q_instr_q[head_q];
  assign imem_addr = pc_q;

  assign pop_s          = fe_valid & fe_ready;
  assign full_s         = (count_q == DEPTH_C);
  // A redirect is ignored during BOOT. It is honoured in every other state.
  assign redirect_act_s = redirect_valid & (state_q != ST_BOOT);
  assign target_s       = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFETCH_BOUNDS_CHECK_EN
  assign oob_s       = ({1'b0, pc_q} >= IMEM_BYTES_C);
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // Next-state logic. A redirect overrides everything. Otherwise the state
  // decides whether to push, and the queue bookkeeping follows from push/pop.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    push_s  = 1'b0;
`ifdef IFETCH_BOUNDS_CHECK_EN
    fault_d = fault_q;
`endif
    if (redirect_act_s) begin
      // Flush: any same-cycle pop is dropped together with the queue contents.
      state_d = ST_RUN;
      pc_d    = target_s;
      count_d = CNT_ZERO_C;
      head_d  = PTR_ZERO_C;
      tail_d  = PTR_ZERO_C;
`ifdef IFETCH_BOUNDS_CHECK_EN
      fault_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
`ifdef IFETCH_BOUNDS_CHECK_EN
          if (oob_s) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            // A full queue can still accept a push if the head leaves this cycle.
            push_s = ~full_s | pop_s;
          end
`else
          push_s = ~full_s | pop_s;
`endif
        end
`ifdef IFETCH_BOUNDS_CHECK_EN
        ST_FAULT: begin
          // Already-queued entries keep draining; only a redirect leaves FAULT.
          state_d = ST_FAULT;
        end
`endif
        default: begin
          state_d = ST_BOOT;
        end
      endcase

      if (push_s) begin
        pc_d   = pc_q + 32'd4;
        tail_d = tail_q + PTR_ONE_C;
      end else begin
        pc_d   = pc_q;
        tail_d = tail_q;
      end

      if (pop_s) begin
        head_d = head_q + PTR_ONE_C;
      end else begin
        head_d = head_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE_C;
        2'b01:   count_d = count_q - CNT_ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  // State, PC, pointer and queue-storage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      count_q <= CNT_ZERO_C;
      head_q  <= PTR_ZERO_C;
      tail_q  <= PTR_ZERO_C;
`ifdef IFETCH_BOUNDS_CHECK_EN
      fault_q <= 1'b0;
`endif
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        q_pc_q[i]    <= 32'h0000_0000;
        q_instr_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
`ifdef IFETCH_BOUNDS_CHECK_EN
      fault_q <= fault_d;
`endif
      if (push_s) begin
        q_pc_q[tail_q]    <= pc_q;
        q_instr_q[tail_q] <= imem_instr;
      end
    end
  end

endmodule
